// File: rtl/pc_pkg.sv
// pc_pkg: shared state type, default vectors and alignment helper for the fetch PC
package pc_pkg;
  typedef enum logic {SEQ, SLOT} pc_state_e;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR = 32'h8000_0180;
  function automatic logic [31:0] align_mask(input int unsigned insn_bytes);
    return 32'(insn_bytes - 1);
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority mux computing the next program-counter state
module pc_next_sel import pc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int INSN_BYTES = 4,
  parameter int DELAY_SLOT = 1,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR)
) (
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_valid_i,
  input  logic             eret_i,
  input  pc_state_e        state_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             bd_i,
  input  logic [WIDTH-1:0] badaddr_i,
  output pc_state_e        state_d_o,
  output logic [WIDTH-1:0] pc_d_o,
  output logic [WIDTH-1:0] tgt_d_o,
  output logic [WIDTH-1:0] epc_d_o,
  output logic             bd_d_o,
  output logic             addr_err_d_o,
  output logic [WIDTH-1:0] badaddr_d_o
);
  localparam logic [WIDTH-1:0] INC = WIDTH'(INSN_BYTES);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(align_mask(INSN_BYTES));
  logic slot, misaligned;
  assign slot = state_i == SLOT;
  assign misaligned = br_valid_i && !slot && !stall_i && (br_target_i & MASK) != '0;
  always_comb begin
    state_d_o = state_i;
    pc_d_o = pc_i;
    tgt_d_o = tgt_i;
    epc_d_o = epc_i;
    bd_d_o = bd_i;
    addr_err_d_o = 1'b0;
    badaddr_d_o = badaddr_i;
    if (exc_valid_i) begin
      pc_d_o = EXC_VECTOR;
      state_d_o = SEQ;
      tgt_d_o = '0;
      epc_d_o = slot ? pc_i - INC : pc_i;
      bd_d_o = slot;
    end else if (eret_i) begin
      pc_d_o = epc_i;
      state_d_o = SEQ;
    end else if (misaligned) begin
      pc_d_o = EXC_VECTOR;
      epc_d_o = pc_i;
      bd_d_o = 1'b0;
      badaddr_d_o = br_target_i;
      addr_err_d_o = 1'b1;
    end else if (!stall_i) begin
      // a branch sitting in the delay slot itself is dropped
      if (slot) begin
        pc_d_o = tgt_i;
        state_d_o = SEQ;
      end else if (br_valid_i && DELAY_SLOT != 0) begin
        pc_d_o = pc_i + INC;
        tgt_d_o = br_target_i;
        state_d_o = SLOT;
      end else begin
        pc_d_o = br_valid_i ? br_target_i : pc_i + INC;
      end
    end
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with delay slot, exceptions and ERET
module pc_unit import pc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int INSN_BYTES = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR),
  parameter int DELAY_SLOT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_valid,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic             in_slot,
  output logic [WIDTH-1:0] epc_out,
  output logic             bd_out,
  output logic             addr_err,
  output logic [WIDTH-1:0] badaddr_out
);
  pc_state_e state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, tgt_q, tgt_d, epc_q, epc_d, badaddr_q, badaddr_d;
  logic bd_q, bd_d, addr_err_q, addr_err_d;
  pc_next_sel #(
    .WIDTH(WIDTH), .INSN_BYTES(INSN_BYTES), .DELAY_SLOT(DELAY_SLOT), .EXC_VECTOR(EXC_VECTOR)
  ) u_sel (
    .stall_i(stall), .br_valid_i(br_valid), .br_target_i(br_target),
    .exc_valid_i(exc_valid), .eret_i(eret),
    .state_i(state_q), .pc_i(pc_q), .tgt_i(tgt_q), .epc_i(epc_q), .bd_i(bd_q), .badaddr_i(badaddr_q),
    .state_d_o(state_d), .pc_d_o(pc_d), .tgt_d_o(tgt_d), .epc_d_o(epc_d), .bd_d_o(bd_d),
    .addr_err_d_o(addr_err_d), .badaddr_d_o(badaddr_d)
  );
  // the datapath samples on the falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= SEQ;
      pc_q <= RESET_VECTOR;
      tgt_q <= '0;
      epc_q <= '0;
      bd_q <= 1'b0;
      addr_err_q <= 1'b0;
      badaddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      epc_q <= epc_d;
      bd_q <= bd_d;
      addr_err_q <= addr_err_d;
      badaddr_q <= badaddr_d;
    end
  end
  assign pc_out = pc_q;
  assign in_slot = state_q == SLOT;
  assign epc_out = epc_q;
  assign bd_out = bd_q;
  assign addr_err = addr_err_q;
  assign badaddr_out = badaddr_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for three pc_unit configurations against a rule-level model
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, br_valid, exc_valid, eret;
  logic [31:0] br_target;
  always #5 clk = ~clk;

  logic [31:0] pc0, epc0, bad0, pc1, epc1, bad1;
  logic [15:0] pc2, epc2, bad2;
  logic sl0, bd0, ae0, sl1, bd1, ae1, sl2, bd2, ae2;

  pc_unit dut0 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .eret(eret), .pc_out(pc0), .in_slot(sl0), .epc_out(epc0),
    .bd_out(bd0), .addr_err(ae0), .badaddr_out(bad0)
  );
  pc_unit #(.DELAY_SLOT(0)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .eret(eret), .pc_out(pc1), .in_slot(sl1), .epc_out(epc1),
    .bd_out(bd1), .addr_err(ae1), .badaddr_out(bad1)
  );
  pc_unit #(.WIDTH(16), .RESET_VECTOR(16'h0000), .EXC_VECTOR(16'h0180)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target[15:0]),
    .exc_valid(exc_valid), .eret(eret), .pc_out(pc2), .in_slot(sl2), .epc_out(epc2),
    .bd_out(bd2), .addr_err(ae2), .badaddr_out(bad2)
  );

  typedef struct packed {
    logic [31:0] pc, tgt, epc, bad;
    logic slot, bd, ae;
  } ms_t;
  typedef struct {
    int id;
    ms_t s;
  } exp_t;

  ms_t model [3];
  exp_t sbq[$];
  int errors = 0, checks = 0;
  logic [31:0] vmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] vexc [3] = '{32'h8000_0180, 32'h8000_0180, 32'h0000_0180};
  bit vds [3] = '{1'b1, 1'b0, 1'b1};

  // one edge of the architectural rules, highest priority first
  function automatic ms_t step(ms_t s, int id, logic r, logic e, logic er, logic st, logic bv, logic [31:0] bt_raw);
    ms_t n = s;
    logic [31:0] m = vmask[id];
    logic [31:0] bt = bt_raw & m;
    n.ae = 1'b0;
    if (r) n = '0;
    else if (e) begin
      n.epc = s.slot ? (s.pc - 32'd4) & m : s.pc;
      n.bd = s.slot;
      n.pc = vexc[id];
      n.slot = 1'b0;
    end else if (er) begin
      n.pc = s.epc;
      n.slot = 1'b0;
    end else if (bv && !s.slot && !st && bt[1:0] != 2'b00) begin
      n.epc = s.pc;
      n.bd = 1'b0;
      n.pc = vexc[id];
      n.bad = bt;
      n.ae = 1'b1;
    end else if (st) n.ae = 1'b0;
    else if (s.slot) begin
      n.pc = s.tgt;
      n.slot = 1'b0;
    end else if (bv && vds[id]) begin
      n.tgt = bt;
      n.pc = (s.pc + 32'd4) & m;
      n.slot = 1'b1;
    end else n.pc = bv ? bt : (s.pc + 32'd4) & m;
    return n;
  endfunction

  task automatic check(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic cyc(logic r, logic e, logic er, logic st, logic bv, logic [31:0] bt);
    @(posedge clk);
    rst = r; exc_valid = e; eret = er; stall = st; br_valid = bv; br_target = bt;
    for (int i = 0; i < 3; i++) begin
      model[i] = step(model[i], i, r, e, er, st, bv, bt);
      sbq.push_back('{id: i, s: model[i]});
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      while (sbq.size() > 0) begin
        x = sbq.pop_front();
        case (x.id)
          0: begin
            check("pc", 0, pc0, x.s.pc); check("in_slot", 0, 32'(sl0), 32'(x.s.slot));
            check("epc", 0, epc0, x.s.epc); check("bd", 0, 32'(bd0), 32'(x.s.bd));
            check("addr_err", 0, 32'(ae0), 32'(x.s.ae)); check("badaddr", 0, bad0, x.s.bad);
          end
          1: begin
            check("pc", 1, pc1, x.s.pc); check("in_slot", 1, 32'(sl1), 32'(x.s.slot));
            check("epc", 1, epc1, x.s.epc); check("bd", 1, 32'(bd1), 32'(x.s.bd));
            check("addr_err", 1, 32'(ae1), 32'(x.s.ae)); check("badaddr", 1, bad1, x.s.bad);
          end
          default: begin
            check("pc", 2, 32'(pc2), x.s.pc); check("in_slot", 2, 32'(sl2), 32'(x.s.slot));
            check("epc", 2, 32'(epc2), x.s.epc); check("bd", 2, 32'(bd2), 32'(x.s.bd));
            check("addr_err", 2, 32'(ae2), 32'(x.s.ae)); check("badaddr", 2, 32'(bad2), x.s.bad);
          end
        endcase
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; exc_valid = 1'b0; eret = 1'b0; br_target = '0;
    for (int i = 0; i < 3; i++) model[i] = '0;
    cyc(1, 0, 0, 0, 0, 32'h0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h100);
    idle(1);
    cyc(0, 0, 0, 0, 1, 32'h400);
    idle(2);
    cyc(0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'h400);
    cyc(0, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 1, 32'h800);
    idle(2);
    cyc(0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'h400);
    cyc(0, 1, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 0, 0, 32'h0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 32'h402);
    idle(1);
    cyc(0, 0, 0, 1, 1, 32'h403);
    cyc(0, 0, 0, 0, 1, 32'hFFFC);
    idle(3);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(3);
    cyc(0, 1, 1, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h40);
    cyc(1, 0, 0, 0, 1, 32'h40);
    cyc(0, 0, 0, 0, 1, 32'h40);
    cyc(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 35, t);
    end
    idle(1);
    @(negedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS_32 fetch stage, replacing the plain PC register. It holds the fetch address, advances it by one instruction per unstalled cycle, and handles stalls, branch/jump redirects with an optional architectural delay slot, exception entry with EPC/BD capture, and ERET. It also detects misaligned branch targets. It sits between the branch-resolution logic, the exception controller and instruction memory.

## Interface
- WIDTH, 32: address width in bits.
- INSN_BYTES, 4: increment per sequential fetch, a power of two.
- RESET_VECTOR, 32'h0000_0000: value loaded into pc_out on reset.
- EXC_VECTOR, 32'h8000_0180: exception entry address.
- DELAY_SLOT, 1: 1 = one branch delay slot; 0 = redirect immediately.

- clk  in  1  clock; all state updates on the falling edge, matching the datapath.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold all state; br_valid is ignored while high.
- br_valid  in  1  taken branch/jump for the instruction at pc_out, one-cycle qualifier.
- br_target  in  WIDTH  redirect address.
- exc_valid  in  1  take exception for the instruction at pc_out.
- eret  in  1  return from exception to epc_out.
- pc_out  out  WIDTH  current fetch address.
- in_slot  out  1  pc_out is a delay-slot instruction.
- epc_out  out  WIDTH  exception program counter.
- bd_out  out  1  last exception was taken in a delay slot.
- addr_err  out  1  one-cycle pulse: misaligned branch target trapped.
- badaddr_out  out  WIDTH  last misaligned target.

## Operation
- **Reset values:** pc_out=RESET_VECTOR, state=SEQ, in_slot=0, epc_out=0, bd_out=0, addr_err=0, badaddr_out=0.
- **States:**
  - SEQ: normal sequential fetch.
  - SLOT: a branch was accepted; the pending target is held in an internal register.
- **Priority, evaluated each edge:** rst > exc_valid > eret > misaligned branch > stall > br_valid > sequential.
- **exc_valid:**
  - pc_out <= EXC_VECTOR, state <= SEQ, pending target discarded, in_slot <= 0.
  - epc_out <= in_slot ? pc_out − INSN_BYTES : pc_out; bd_out <= in_slot.
  - Overrides stall.
- **eret:** pc_out <= epc_out, state <= SEQ, in_slot <= 0. Overrides stall.
- **Misaligned branch:** br_valid with br_target[log2(INSN_BYTES)−1:0] ≠ 0, in SEQ, stall=0.
  - Treated as an exception: pc_out <= EXC_VECTOR, epc_out <= pc_out, bd_out <= 0.
  - badaddr_out <= br_target; addr_err pulses for one cycle.
- **stall:** pc_out, state, pending target and in_slot hold. addr_err is forced to 0.
- **br_valid in SEQ, aligned:**
  - DELAY_SLOT=1: pc_out <= pc_out+INSN_BYTES, target latched, state <= SLOT, in_slot <= 1.
  - DELAY_SLOT=0: pc_out <= br_target.
- **SLOT, unstalled:** pc_out <= pending target, state <= SEQ, in_slot <= 0. A br_valid here (branch in a delay slot) is ignored.
- **Sequential:** pc_out <= pc_out + INSN_BYTES, modulo 2^WIDTH. Wrap from all-ones to 0 is silent.
- **eret and exc_valid together:** exc_valid wins.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Exception/ERET redirect: visible on pc_out one edge after assertion.
- Branch, DELAY_SLOT=1: target appears two unstalled edges after br_valid; a stall in SLOT extends this.
- Branch, DELAY_SLOT=0: target appears one edge after br_valid.
- rst while in SLOT: pending target discarded, all outputs return to their reset values on that edge.

## Structure
- Shared package pc_pkg:
  - state enum {SEQ, SLOT}.
  - default RESET_VECTOR and EXC_VECTOR constants.
  - an alignment-mask function of INSN_BYTES.
- One sub-module, pc_next_sel: purely combinational priority mux producing next_pc, next_state, next_epc and flags. The top-level holds only registers.
- Expected size: roughly 200 lines total.

## Test plan
- Reset then 3 unstalled edges: pc_out = 0, 4, 8, C. Then rst asserted: pc_out = 0 on the next edge.
- pc_out = 0x100, br_valid with br_target = 0x400 (DELAY_SLOT=1): next pc_out = 0x104 with in_slot=1, then 0x400 with in_slot=0. Same with stall held 2 cycles in SLOT: 0x104 holds 2 extra cycles before 0x400.
- exc_valid while pc_out = 0x104 in SLOT: pc_out = 0x8000_0180, epc_out = 0x100, bd_out=1. Then eret: pc_out = 0x100.
- br_valid with br_target = 0x402: addr_err pulses for one cycle, badaddr_out = 0x402, pc_out = 0x8000_0180, epc_out = branch PC.
- WIDTH=16, pc_out = 0xFFFC, no branch: pc_out = 0x0000 on the next edge. exc_valid together with stall and eret: exception taken.
- DELAY_SLOT=0, br_valid with br_target = 0x40: pc_out = 0x40 next edge, in_slot stays 0.
